// File: rtl/huffman_bit_packer.sv
`timescale 1ns/1ps
// huffman_bit_packer: latches a six-entry Huffman code table and packs symbol
// codes MSB-first into bytes, zero-padding the final byte of each message.
module huffman_bit_packer #(
  parameter int BUF_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  input  logic       sym_last,
  output logic       sym_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic [3:0] pad_bits,
  output logic       table_err,
  output logic       sym_err
);

  localparam int NW = $clog2(BUF_W + 1);
  localparam logic [NW-1:0] N_BYTE = NW'(8);
  localparam logic [NW-1:0] N_FULL = NW'(BUF_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [3:0] mask_ones(input logic [7:0] m);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, m[i]};
    end
    return cnt;
  endfunction

  function automatic logic [7:0] len_mask(input logic [3:0] len);
    logic [8:0] full;
    full = (9'd1 << len) - 9'd1;
    return full[7:0];
  endfunction

  // A mask is usable only as a contiguous run of 1..8 ones starting at bit 0.
  function automatic logic mask_is_run(input logic [7:0] m, input logic [3:0] len);
    return (len != 4'd0) && (m == len_mask(len));
  endfunction

  state_t           state_q, state_d;
  logic             code_valid_q, code_valid_d;
  logic [7:0]       code_q [0:5];
  logic [7:0]       code_d [0:5];
  logic [3:0]       len_q  [0:5];
  logic [3:0]       len_d  [0:5];
  logic [BUF_W-1:0] acc_q, acc_d;
  logic [NW-1:0]    n_q, n_d;
  logic             sym_ready_q, sym_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [3:0]       pad_bits_q, pad_bits_d;
  logic             table_err_q, table_err_d;
  logic             sym_err_q, sym_err_d;

  logic [7:0]       hc_in [0:5];
  logic [7:0]       m_in  [0:5];
  logic             cap_edge, cap, sym_hs, out_hs, sym_bad;
  logic [2:0]       sym_idx;
  logic [3:0]       sym_len, ones;
  logic [7:0]       sym_code;
  logic [BUF_W-1:0] acc_sh, ins;
  logic [NW-1:0]    n_sh, ins_sh;

  // Next-state, table capture, accumulator update and registered output decode.
  always_comb begin
    state_d      = state_q;
    code_valid_d = code_valid;
    code_d       = code_q;
    len_d        = len_q;
    acc_d        = acc_q;
    n_d          = n_q;
    table_err_d  = table_err_q;
    sym_err_d    = sym_err_q;
    ones         = 4'd0;

    hc_in[0] = HC1; hc_in[1] = HC2; hc_in[2] = HC3;
    hc_in[3] = HC4; hc_in[4] = HC5; hc_in[5] = HC6;
    m_in[0]  = M1;  m_in[1]  = M2;  m_in[2]  = M3;
    m_in[3]  = M4;  m_in[4]  = M5;  m_in[5]  = M6;

    sym_hs   = sym_valid & sym_ready_q;
    out_hs   = out_valid_q & out_ready;
    cap_edge = code_valid & ~code_valid_q;
    cap      = cap_edge & ((state_q == IDLE) |
                           ((state_q == RUN) & (n_q == '0) & ~sym_hs));

    case (sym_data)
      8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6: begin
        sym_idx = 3'(sym_data - 8'd1);
        sym_bad = 1'b0;
      end
      default: begin
        sym_idx = 3'd0;
        sym_bad = 1'b1;
      end
    endcase
    sym_len  = sym_bad ? 4'd0 : len_q[sym_idx];
    sym_code = sym_bad ? 8'd0 : (code_q[sym_idx] & len_mask(sym_len));

    // Emission happens first so a same-cycle accept lands behind the freed byte.
    acc_sh = out_hs ? (acc_q << 4'd8) : acc_q;
    n_sh   = out_hs ? ((n_q >= N_BYTE) ? (n_q - N_BYTE) : '0) : n_q;
    ins_sh = N_FULL - n_sh - NW'(sym_len);
    ins    = {{(BUF_W-8){1'b0}}, sym_code} << ins_sh;

    if (cap) begin
      for (int k = 0; k < 6; k++) begin
        ones = mask_ones(m_in[k]);
        code_d[k] = hc_in[k];
        if (mask_is_run(m_in[k], ones)) begin
          len_d[k] = ones;
        end else begin
          len_d[k]    = 4'd0;
          table_err_d = 1'b1;
        end
      end
    end else begin
      table_err_d = table_err_q;
    end

    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = RUN;
          acc_d   = '0;
          n_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_sh;
        n_d   = n_sh;
        if (sym_hs) begin
          acc_d = acc_sh | ins;
          n_d   = n_sh + NW'(sym_len);
          if (sym_bad) begin
            sym_err_d = 1'b1;
          end else begin
            sym_err_d = sym_err_q;
          end
          if (sym_last) begin
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (out_hs && (n_q <= N_BYTE)) begin
          acc_d   = '0;
          n_d     = '0;
          state_d = RUN;
        end else if (out_hs) begin
          acc_d = acc_sh;
          n_d   = n_sh;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        n_d     = '0;
      end
    endcase

    sym_ready_d = (state_d == RUN) && (n_d <= N_BYTE);
    out_valid_d = ((state_d == RUN) && (n_d >= N_BYTE)) || (state_d == FLUSH);
    out_last_d  = (state_d == FLUSH) && (n_d <= N_BYTE);
    pad_bits_d  = out_last_d ? 4'(N_BYTE - n_d) : 4'd0;
    out_data_d  = acc_d[BUF_W-1 -: 8];
  end

  // State, table and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      code_valid_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        code_q[k] <= 8'd0;
        len_q[k]  <= 4'd0;
      end
      acc_q        <= '0;
      n_q          <= '0;
      sym_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'd0;
      out_last_q   <= 1'b0;
      pad_bits_q   <= 4'd0;
      table_err_q  <= 1'b0;
      sym_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_valid_q <= code_valid_d;
      code_q       <= code_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      n_q          <= n_d;
      sym_ready_q  <= sym_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      pad_bits_q   <= pad_bits_d;
      table_err_q  <= table_err_d;
      sym_err_q    <= sym_err_d;
    end
  end

  assign sym_ready = sym_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign pad_bits  = pad_bits_q;
  assign table_err = table_err_q;
  assign sym_err   = sym_err_q;

endmodule

// File: tb/tb_huffman_bit_packer.sv
`timescale 1ns/1ps
// Self-checking bench for huffman_bit_packer: directed messages plus random
// tables/messages scored against a bit-queue reference model.
module tb_huffman_bit_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0] M1, M2, M3, M4, M5, M6;
  logic       sym_valid;
  logic [7:0] sym_data;
  logic       sym_last;
  logic       sym_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic [3:0] pad_bits;
  logic       table_err;
  logic       sym_err;

  int checks = 0;
  int errors = 0;

  int         sym_q[$];
  logic [7:0] exp_data_q[$];
  logic       exp_last_q[$];
  logic [3:0] exp_pad_q[$];

  logic [7:0] tb_hc [1:6];
  logic [7:0] tb_m  [1:6];
  int         mdl_len [1:6];
  logic [7:0] mdl_code [1:6];
  bit         exp_table_err = 1'b0;
  bit         exp_sym_err = 1'b0;
  int         stall_acc;
  int         simul_cnt;

  huffman_bit_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
    .sym_ready(sym_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .pad_bits(pad_bits),
    .table_err(table_err), .sym_err(sym_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int ref_len(input logic [7:0] m);
    for (int l = 1; l <= 8; l++) begin
      if (int'(m) == (1 << l) - 1) return l;
    end
    return 0;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic l, input logic [3:0] p);
    exp_data_q.push_back(d);
    exp_last_q.push_back(l);
    exp_pad_q.push_back(p);
  endtask

  // Reference: concatenate code bits, zero-pad to a byte, cut into bytes.
  task automatic build_expected();
    bit         bits[$];
    int         pad;
    int         nbytes;
    logic [7:0] by;
    foreach (sym_q[i]) begin
      if (sym_q[i] >= 1 && sym_q[i] <= 6) begin
        for (int b = mdl_len[sym_q[i]] - 1; b >= 0; b--) bits.push_back(mdl_code[sym_q[i]][b]);
      end else begin
        exp_sym_err = 1'b1;
      end
    end
    pad = (8 - (bits.size() % 8)) % 8;
    repeat (pad) bits.push_back(1'b0);
    nbytes = bits.size() / 8;
    for (int i = 0; i < nbytes; i++) begin
      for (int j = 0; j < 8; j++) by[7-j] = bits[8*i + j];
      push_exp(by, (i == nbytes - 1), (i == nbytes - 1) ? 4'(pad) : 4'd0);
    end
  endtask

  task automatic set_table_a();
    tb_hc[1] = 8'h00; tb_hc[2] = 8'h02; tb_hc[3] = 8'h06;
    tb_hc[4] = 8'h0E; tb_hc[5] = 8'h1E; tb_hc[6] = 8'h1F;
    tb_m[1]  = 8'h01; tb_m[2]  = 8'h03; tb_m[3]  = 8'h07;
    tb_m[4]  = 8'h0F; tb_m[5]  = 8'h1F; tb_m[6]  = 8'h1F;
  endtask

  task automatic load_table();
    @(posedge clk); #1;
    sym_valid = 1'b0;
    code_valid = 1'b0;
    HC1 = tb_hc[1]; HC2 = tb_hc[2]; HC3 = tb_hc[3];
    HC4 = tb_hc[4]; HC5 = tb_hc[5]; HC6 = tb_hc[6];
    M1 = tb_m[1]; M2 = tb_m[2]; M3 = tb_m[3];
    M4 = tb_m[4]; M5 = tb_m[5]; M6 = tb_m[6];
    for (int k = 1; k <= 6; k++) begin
      mdl_len[k] = ref_len(tb_m[k]);
      mdl_code[k] = tb_hc[k];
      if (mdl_len[k] == 0) exp_table_err = 1'b1;
    end
    @(posedge clk); #1;
    code_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (table_err !== exp_table_err) begin
      errors++;
      $display("FAIL table_err: got %b expected %b", table_err, exp_table_err);
    end
  endtask

  // Drives sym_q and scores every output handshake against the expected queues.
  task automatic run_stream(input int vmode, input int rmode, input int stall_cyc);
    int         si = 0;
    int         cyc = 0;
    bit         acc, emit, prev_stall;
    logic [7:0] pd;
    logic       pl;
    logic [3:0] pp;
    prev_stall = 1'b0;
    stall_acc = 0;
    simul_cnt = 0;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    while ((si < sym_q.size() || exp_data_q.size() > 0) && cyc < 2000) begin
      if (si < sym_q.size()) begin
        if (!sym_valid) sym_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        sym_data = 8'(sym_q[si]);
        sym_last = (si == sym_q.size() - 1);
      end else begin
        sym_valid = 1'b0;
        sym_last = 1'b0;
      end
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = (cyc < stall_cyc) ? 1'b0 : 1'b1;
      endcase
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl || pad_bits !== pp) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b p=%0d expected v=1 d=%h l=%b p=%0d",
                   out_valid, out_data, out_last, pad_bits, pd, pl, pp);
        end
      end
      acc  = sym_valid && sym_ready;
      emit = out_valid && out_ready;
      if (acc && emit) simul_cnt++;
      if (acc && !out_ready) stall_acc++;
      if (emit) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got d=%h l=%b expected no byte", out_data, out_last);
        end else begin
          if (out_data !== exp_data_q[0] || out_last !== exp_last_q[0] || pad_bits !== exp_pad_q[0]) begin
            errors++;
            $display("FAIL out_byte: got d=%h l=%b p=%0d expected d=%h l=%b p=%0d",
                     out_data, out_last, pad_bits, exp_data_q[0], exp_last_q[0], exp_pad_q[0]);
          end
          void'(exp_data_q.pop_front());
          void'(exp_last_q.pop_front());
          void'(exp_pad_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      pp = pad_bits;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        si++;
        sym_valid = 1'b0;
      end
    end
    sym_valid = 1'b0;
    sym_last = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL stream_timeout: got %0d bytes pending expected 0", exp_data_q.size());
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_msg: got out_valid=%b expected 0", out_valid);
    end
    sym_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    exp_pad_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; code_valid = 1'b0; sym_valid = 1'b0; sym_data = 8'd0; sym_last = 1'b0;
    out_ready = 1'b0;
    {HC1, HC2, HC3, HC4, HC5, HC6} = 48'd0;
    {M1, M2, M3, M4, M5, M6} = 48'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sym_ready, out_valid, out_data, out_last, pad_bits, table_err, sym_err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {sym_ready, out_valid, out_data, out_last, pad_bits, table_err, sym_err});
    end
    reset = 1'b0;
    sym_valid = 1'b1; sym_data = 8'd1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sym_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_table: got rdy=%b v=%b expected 0 0", sym_ready, out_valid);
      end
    end
    sym_valid = 1'b0;
  endtask

  task automatic test_basic_message();
    set_table_a();
    load_table();
    sym_q = '{1, 2, 3, 4};
    push_exp(8'h5B, 1'b0, 4'd0);
    push_exp(8'h80, 1'b1, 4'd6);
    run_stream(0, 0, 0);
  endtask

  task automatic test_single_byte();
    repeat (8) sym_q.push_back(1);
    push_exp(8'h00, 1'b1, 4'd0);
    run_stream(0, 0, 0);
  endtask

  task automatic test_full_bytes();
    repeat (8) sym_q.push_back(6);
    for (int i = 0; i < 5; i++) push_exp(8'hFF, (i == 4), 4'd0);
    run_stream(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    repeat (8) sym_q.push_back(4);
    for (int i = 0; i < 4; i++) push_exp(8'hEE, (i == 3), 4'd0);
    run_stream(0, 0, 0);
    checks++;
    if (simul_cnt != 3) begin
      errors++;
      $display("FAIL simultaneous_accept_emit: got %0d cycles expected 3", simul_cnt);
    end
  endtask

  task automatic test_stall();
    repeat (8) sym_q.push_back(6);
    for (int i = 0; i < 5; i++) push_exp(8'hFF, (i == 4), 4'd0);
    run_stream(0, 2, 12);
    checks++;
    if (stall_acc != 2) begin
      errors++;
      $display("FAIL stall_accepts: got %0d expected 2", stall_acc);
    end
  endtask

  task automatic test_random(input bit allow_err, input int ntables);
    int nsym, s;
    for (int t = 0; t < ntables; t++) begin
      for (int k = 1; k <= 6; k++) begin
        if (k > 1 && allow_err && $urandom_range(0, 3) == 0) begin
          tb_m[k] = 8'($urandom);
        end else begin
          tb_m[k] = 8'((1 << $urandom_range(1, 8)) - 1);
        end
        tb_hc[k] = 8'($urandom);
      end
      load_table();
      for (int msg = 0; msg < 6; msg++) begin
        nsym = $urandom_range(1, 12);
        for (int i = 0; i < nsym - 1; i++) begin
          if (allow_err && $urandom_range(0, 5) == 0) begin
            s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(7, 255);
          end else begin
            s = $urandom_range(1, 6);
          end
          sym_q.push_back(s);
        end
        s = $urandom_range(1, 6);
        for (int g = 0; g < 20 && mdl_len[s] == 0; g++) s = $urandom_range(1, 6);
        if (mdl_len[s] == 0) s = 1;
        sym_q.push_back(s);
        build_expected();
        run_stream(1, 1, 0);
        checks++;
        if (sym_err !== exp_sym_err) begin
          errors++;
          $display("FAIL sym_err_random: got %b expected %b", sym_err, exp_sym_err);
        end
      end
    end
  endtask

  task automatic test_errors();
    set_table_a();
    tb_m[3] = 8'h05;
    load_table();
    checks++;
    if (table_err !== 1'b1) begin
      errors++;
      $display("FAIL table_err_bad_mask: got %b expected 1", table_err);
    end
    sym_q = '{1, 3, 7, 2, 4};
    push_exp(8'h5C, 1'b1, 4'd1);
    exp_sym_err = 1'b1;
    run_stream(0, 0, 0);
    checks++;
    if (sym_err !== 1'b1) begin
      errors++;
      $display("FAIL sym_err_illegal: got %b expected 1", sym_err);
    end
  endtask

  task automatic test_reset_flush();
    set_table_a();
    load_table();
    @(posedge clk); #1;
    sym_valid = 1'b1; sym_data = 8'd6; sym_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    sym_last = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_last = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b0 || out_data !== 8'hFF) begin
      errors++;
      $display("FAIL flush_pending: got v=%b l=%b d=%h expected v=1 l=0 d=ff",
               out_valid, out_last, out_data);
    end
    reset = 1'b1;
    code_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sym_ready, out_valid, out_data, out_last, pad_bits, table_err, sym_err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_in_flush: got %h expected 0",
               {sym_ready, out_valid, out_data, out_last, pad_bits, table_err, sym_err});
    end
    exp_table_err = 1'b0;
    exp_sym_err = 1'b0;
    reset = 1'b0;
    sym_valid = 1'b1; sym_data = 8'd1; sym_last = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (sym_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: got rdy=%b v=%b expected 0 0", sym_ready, out_valid);
      end
    end
    sym_valid = 1'b0; sym_last = 1'b0;
    load_table();
    sym_q = '{1, 2, 3, 4};
    push_exp(8'h5B, 1'b0, 4'd0);
    push_exp(8'h80, 1'b1, 4'd6);
    run_stream(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_message();
    test_single_byte();
    test_full_bytes();
    test_back_to_back();
    test_stall();
    test_random(1'b0, 3);
    test_errors();
    test_random(1'b1, 3);
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
